// File: rtl/joker_ts_ingest_mc.sv
// Round-robin drain of NCH USB bulk OUT buffers into the shared TS FIFO,
// with per-channel 188-byte packet alignment tracking and event counters.
module joker_ts_ingest_mc #(
  parameter int NCH        = 2,
  parameter int LEN_W      = 11,
  parameter int RD_LAT     = 2,
  parameter int CLK_PER_MS = 60000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       buf_hasdata,
  input  logic [NCH*LEN_W-1:0] buf_len,
  input  logic [NCH*8-1:0]     buf_q,
  output logic [NCH*LEN_W-1:0] buf_addr,
  output logic [NCH-1:0]       buf_arm,
  input  logic [NCH-1:0]       buf_arm_ack,
  output logic [7:0]           ts_data,
  output logic [2:0]           ts_chan,
  output logic                 ts_sop,
  output logic                 ts_writereq,
  input  logic                 ts_almost_full,
  output logic [29:0]          total_bytes,
  output logic [15:0]          sync_err_cnt,
  output logic [15:0]          timeout_cnt,
  output logic                 active
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [7:0] SYNC = 8'h47;

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_RDWAIT, S_WRITE, S_GAP, S_FINISH
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             gnt_q, gnt_d, last_q, last_d;
  logic [LEN_W-1:0]          len_q, len_d, proc_q, proc_d;
  logic [7:0]                ms_q, ms_d;
  logic [CW-1:0]             ms_cnt_q, ms_cnt_d;
  logic [2:0]                rd_cnt_q, rd_cnt_d;
  logic [NCH-1:0][7:0]       off_q, off_d;
  logic [NCH-1:0][LEN_W-1:0] addr_q, addr_d;
  logic [NCH-1:0]            arm_q, arm_d, ack_prev_q;
  logic [7:0]                data_q, data_d;
  logic [2:0]                chan_q, chan_d;
  logic                      sop_q, sop_d, wr_q, wr_d;
  logic [29:0]               total_q, total_d;
  logic [15:0]               sync_q, sync_d, tmo_q, tmo_d;

  logic [NCH-1:0][LEN_W-1:0] len_v;
  logic [NCH-1:0][7:0]       q_v;
  logic [7:0]                cur_byte, cur_off;
  logic                      ack_fall, found;
  logic [IW-1:0]             pick;

  assign len_v    = buf_len;
  assign q_v      = buf_q;
  assign cur_byte = q_v[gnt_q];
  assign cur_off  = off_q[gnt_q];
  assign ack_fall = ack_prev_q[gnt_q] & ~buf_arm_ack[gnt_q];

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned k);
    return IW'((32'(base) + k) % 32'(NCH));
  endfunction

  // First requester after the last served channel wins.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int unsigned k = 1; k <= NCH; k++) begin
      if (!found && buf_hasdata[rr_idx(last_q, k)]) begin
        found = 1'b1;
        pick  = rr_idx(last_q, k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    len_d    = len_q;
    proc_d   = proc_q;
    rd_cnt_d = rd_cnt_q;
    off_d    = off_q;
    addr_d   = addr_q;
    arm_d    = arm_q;
    data_d   = data_q;
    chan_d   = chan_q;
    sop_d    = 1'b0;
    wr_d     = 1'b0;
    total_d  = total_q;
    sync_d   = sync_q;
    tmo_d    = tmo_q;
    if (ms_cnt_q == CW'(CLK_PER_MS - 1)) begin
      ms_cnt_d = '0;
      ms_d     = (ms_q == 8'hFF) ? ms_q : ms_q + 8'd1;
    end else begin
      ms_cnt_d = ms_cnt_q + 1'b1;
      ms_d     = ms_q;
    end

    case (state_q)
      S_IDLE: if (|buf_hasdata) state_d = S_ARB;
      S_ARB: begin
        if (!found) begin
          state_d = S_IDLE;
        end else begin
          gnt_d        = pick;
          len_d        = len_v[pick];
          addr_d[pick] = '0;
          proc_d       = '0;
          ms_d         = '0;
          ms_cnt_d     = '0;
          state_d      = (len_v[pick] == '0) ? S_FINISH : S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (rd_cnt_q == 3'(RD_LAT - 1)) begin
          rd_cnt_d = '0;
          state_d  = S_WRITE;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
      S_WRITE: begin
        if (proc_q == len_q) begin
          state_d = S_FINISH;
        end else if (ms_q >= 8'(TIMEOUT_MS)) begin
          tmo_d   = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
          state_d = S_FINISH;
        end else if (!ts_almost_full) begin
          data_d        = cur_byte;
          chan_d        = 3'(gnt_q);
          wr_d          = 1'b1;
          proc_d        = proc_q + 1'b1;
          total_d       = total_q + 30'd1;
          addr_d[gnt_q] = addr_q[gnt_q] + 1'b1;
          // Offset 0 without a sync byte stays in hunt mode.
          if (cur_off == 8'd0) begin
            if (cur_byte == SYNC) begin
              sop_d        = 1'b1;
              off_d[gnt_q] = 8'd1;
            end else begin
              sync_d = (sync_q == 16'hFFFF) ? sync_q : sync_q + 16'd1;
            end
          end else begin
            off_d[gnt_q] = (cur_off == 8'd187) ? '0 : cur_off + 8'd1;
          end
          state_d = S_GAP;
        end
      end
      S_GAP: state_d = (proc_q == len_q) ? S_WRITE : S_RDWAIT;
      S_FINISH: begin
        if (ack_fall) begin
          arm_d[gnt_q] = 1'b0;
          last_d       = gnt_q;
          state_d      = S_IDLE;
        end else begin
          arm_d[gnt_q] = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      last_q     <= IW'(NCH - 1);
      len_q      <= '0;
      proc_q     <= '0;
      ms_q       <= '0;
      ms_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      arm_q      <= '0;
      ack_prev_q <= '0;
      data_q     <= '0;
      chan_q     <= '0;
      sop_q      <= 1'b0;
      wr_q       <= 1'b0;
      total_q    <= '0;
      sync_q     <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      len_q      <= len_d;
      proc_q     <= proc_d;
      ms_q       <= ms_d;
      ms_cnt_q   <= ms_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      arm_q      <= arm_d;
      ack_prev_q <= buf_arm_ack;
      data_q     <= data_d;
      chan_q     <= chan_d;
      sop_q      <= sop_d;
      wr_q       <= wr_d;
      total_q    <= total_d;
      sync_q     <= sync_d;
      tmo_q      <= tmo_d;
    end
  end

  assign buf_addr     = addr_q;
  assign buf_arm      = arm_q;
  assign ts_data      = data_q;
  assign ts_chan      = chan_q;
  assign ts_sop       = sop_q;
  assign ts_writereq  = wr_q;
  assign total_bytes  = total_q;
  assign sync_err_cnt = sync_q;
  assign timeout_cnt  = tmo_q;
  assign active       = (state_q != S_IDLE);

endmodule

// File: tb/tb_joker_ts_ingest_mc.sv
// Scoreboard bench for joker_ts_ingest_mc: buffer/ack model per channel,
// expected writes queued at stimulus time, popped by a negedge monitor.
module tb_joker_ts_ingest_mc;
  localparam int NCH        = 2;
  localparam int LEN_W      = 11;
  localparam int RD_LAT     = 2;
  localparam int CLK_PER_MS = 10;
  localparam int TIMEOUT_MS = 200;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       buf_hasdata;
  logic [NCH*LEN_W-1:0] buf_len;
  logic [NCH*8-1:0]     buf_q;
  logic [NCH*LEN_W-1:0] buf_addr;
  logic [NCH-1:0]       buf_arm;
  logic [NCH-1:0]       buf_arm_ack;
  logic [7:0]           ts_data;
  logic [2:0]           ts_chan;
  logic                 ts_sop;
  logic                 ts_writereq;
  logic                 ts_almost_full;
  logic [29:0]          total_bytes;
  logic [15:0]          sync_err_cnt;
  logic [15:0]          timeout_cnt;
  logic                 active;

  always #5 clk = ~clk;

  joker_ts_ingest_mc #(
    .NCH(NCH), .LEN_W(LEN_W), .RD_LAT(RD_LAT),
    .CLK_PER_MS(CLK_PER_MS), .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk(clk), .reset(reset), .buf_hasdata(buf_hasdata), .buf_len(buf_len),
    .buf_q(buf_q), .buf_addr(buf_addr), .buf_arm(buf_arm), .buf_arm_ack(buf_arm_ack),
    .ts_data(ts_data), .ts_chan(ts_chan), .ts_sop(ts_sop), .ts_writereq(ts_writereq),
    .ts_almost_full(ts_almost_full), .total_bytes(total_bytes),
    .sync_err_cnt(sync_err_cnt), .timeout_cnt(timeout_cnt), .active(active)
  );

  // Buffer memories with an RD_LAT-deep read pipeline.
  logic [7:0]       mem  [NCH][2048];
  logic [7:0]       pipe [NCH][RD_LAT];
  logic [LEN_W-1:0] len_r[NCH];

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      pipe[c][0] <= mem[c][buf_addr[c*LEN_W +: LEN_W]];
      for (int k = 1; k < RD_LAT; k++) pipe[c][k] <= pipe[c][k-1];
    end
  end

  always_comb begin
    buf_q   = '0;
    buf_len = '0;
    for (int c = 0; c < NCH; c++) begin
      buf_q[c*8 +: 8]           = pipe[c][RD_LAT-1];
      buf_len[c*LEN_W +: LEN_W] = len_r[c];
    end
  end

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] d;
    logic       sop;
  } item_t;

  item_t       exp_q[$];
  int          m_off[NCH];
  int unsigned exp_total, exp_sync;
  int          checks = 0, errors = 0;
  int          wr_seen = 0, sop_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill(input int ch, input int n, input int seed);
    for (int i = 0; i < n; i++) mem[ch][i] = 8'(i * 5 + seed);
    len_r[ch] = LEN_W'(n);
  endtask

  task automatic push_buf(input int ch, input int n);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it.ch = 3'(ch);
      it.d = mem[ch][i];
      it.sop = 1'b0;
      if (m_off[ch] == 0) begin
        if (it.d == 8'h47) begin
          it.sop = 1'b1;
          m_off[ch] = 1;
        end else begin
          exp_sync++;
        end
      end else begin
        m_off[ch] = (m_off[ch] == 187) ? 0 : m_off[ch] + 1;
      end
      exp_q.push_back(it);
      exp_total++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int c = 0; c < NCH; c++) m_off[c] = 0;
    exp_total = 0;
    exp_sync  = 0;
  endtask

  task automatic serve(input int ch);
    int n;
    n = 0;
    while (!buf_arm[ch] && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("arm_raise_ch%0d", ch), 32'(buf_arm[ch]), 1);
    if (!buf_arm[ch]) begin
      buf_hasdata[ch] = 1'b0;
      return;
    end
    repeat (2) @(posedge clk);
    #1 buf_arm_ack[ch] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk($sformatf("arm_held_ch%0d", ch), 32'(buf_arm[ch]), 1);
    buf_arm_ack[ch] = 1'b0;
    buf_hasdata[ch] = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk($sformatf("arm_release_ch%0d", ch), 32'(buf_arm[ch]), 0);
  endtask

  task automatic monitor();
    item_t it;
    logic  prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ts_writereq) begin
        wr_seen++;
        if (ts_sop) sop_seen++;
        chk("wr_spacing", 32'(prev), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_write: got chan=%0d data=0x%0h, expected no write", ts_chan, ts_data);
        end else begin
          it = exp_q.pop_front();
          chk("sb_write {chan,data,sop}", {20'b0, ts_chan, ts_data, ts_sop},
              {20'b0, it.ch, it.d, it.sop});
        end
      end
      prev = ts_writereq;
    end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_drained"}, 32'(exp_q.size()), 0);
    chk({tag, "_total"}, 32'(total_bytes), exp_total);
    chk({tag, "_sync"}, 32'(sync_err_cnt), exp_sync);
    chk({tag, "_idle"}, 32'(active), 0);
  endtask

  task automatic run_tests();
    int base, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 32'(buf_addr), 0);
    chk("rst_arm", 32'(buf_arm), 0);
    chk("rst_ts", {20'b0, ts_chan, ts_data, ts_sop}, 0);
    chk("rst_wr", 32'(ts_writereq), 0);
    chk("rst_cnts", 32'(total_bytes) | 32'(sync_err_cnt) | 32'(timeout_cnt), 0);
    chk("rst_active", 32'(active), 0);
    reset = 1'b0;

    // Two aligned packets on ch0.
    fill(0, 376, 3);
    mem[0][0] = 8'h47;
    mem[0][188] = 8'h47;
    push_buf(0, 376);
    sop_seen = 0;
    buf_hasdata[0] = 1'b1;
    serve(0);
    chk("pkt2_sops", 32'(sop_seen), 2);
    chk("pkt2_total", 32'(total_bytes), 376);
    check_counters("pkt2");

    // Bad sync: 0x00 then 0x47 locks alignment.
    fill(0, 189, 7);
    mem[0][0] = 8'h00;
    mem[0][1] = 8'h47;
    push_buf(0, 189);
    sop_seen = 0;
    buf_hasdata[0] = 1'b1;
    serve(0);
    chk("badsync_sops", 32'(sop_seen), 1);
    chk("badsync_cnt", 32'(sync_err_cnt), 1);
    check_counters("badsync");

    // One packet split across ch1 buffers of 100 and 88, then a new packet.
    sop_seen = 0;
    fill(1, 100, 11);
    mem[1][0] = 8'h47;
    push_buf(1, 100);
    buf_hasdata[1] = 1'b1;
    serve(1);
    fill(1, 88, 13);
    mem[1][0] = 8'h00;
    push_buf(1, 88);
    buf_hasdata[1] = 1'b1;
    serve(1);
    fill(1, 10, 17);
    mem[1][0] = 8'h47;
    push_buf(1, 10);
    buf_hasdata[1] = 1'b1;
    serve(1);
    chk("span_sops", 32'(sop_seen), 2);
    chk("span_sync", 32'(sync_err_cnt), 1);
    check_counters("span");

    // Simultaneous requests: ch0 then ch1, twice.
    for (int p = 0; p < 2; p++) begin
      fill(0, 4, 1);
      mem[0][0] = 8'h47;
      fill(1, 4, 10);
      push_buf(0, 4);
      push_buf(1, 4);
      buf_hasdata = 2'b11;
      fork
        serve(0);
        serve(1);
      join
      check_counters($sformatf("alt%0d", p));
    end

    // Backpressure held until the drain timeout fires.
    base = wr_seen;
    fill(0, 50, 2);
    ts_almost_full = 1'b1;
    buf_hasdata[0] = 1'b1;
    serve(0);
    ts_almost_full = 1'b0;
    chk("tmo_cnt", 32'(timeout_cnt), 1);
    chk("tmo_nowrites", 32'(wr_seen - base), 0);
    check_counters("tmo");

    // Zero-length buffer is released without writes.
    base = wr_seen;
    len_r[1] = '0;
    buf_hasdata[1] = 1'b1;
    serve(1);
    chk("len0_nowrites", 32'(wr_seen - base), 0);
    chk("len0_tmo", 32'(timeout_cnt), 1);
    check_counters("len0");

    // Reset after 10 of 100 bytes, then full re-serve from address 0.
    base = wr_seen;
    fill(0, 100, 5);
    mem[0][0] = 8'h47;
    push_buf(0, 100);
    buf_hasdata[0] = 1'b1;
    n = 0;
    while (wr_seen < base + 10 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrst_10writes", 32'(wr_seen - base), 10);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_addr", 32'(buf_addr), 0);
    chk("midrst_arm_wr", {30'b0, ts_writereq, |buf_arm}, 0);
    chk("midrst_cnts", 32'(total_bytes) | 32'(sync_err_cnt) | 32'(timeout_cnt), 0);
    chk("midrst_active", 32'(active), 0);
    model_reset();
    push_buf(0, 100);
    reset = 1'b0;
    sop_seen = 0;
    serve(0);
    chk("midrst_total", 32'(total_bytes), 100);
    chk("midrst_sops", 32'(sop_seen), 1);
    chk("midrst_tmo", 32'(timeout_cnt), 0);
    check_counters("midrst");
  endtask

  initial begin
    reset = 1'b1;
    buf_hasdata = '0;
    buf_arm_ack = '0;
    ts_almost_full = 1'b0;
    for (int c = 0; c < NCH; c++) len_r[c] = '0;
    model_reset();
    fork
      monitor();
      run_tests();
      begin
        repeat (60000) @(posedge clk);
        checks++;
        errors++;
        $display("FAIL watchdog: run still busy after 60000 cycles, expected completion");
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
